uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_byte_fifo.sv | 56 +++++
 rtl/uart_tx_fifo.sv | 108 ++++++++++
 tb/tb_uart_tx_fifo.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: payload width and the tx-side FIFO launch FSM encoding.
package uart_pkg;

   localparam int UART_PAYLOAD_BITS = 8;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_ACK  = 2'd1,
      ST_WAIT_DONE = 2'd2
   } tx_fifo_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular word buffer with a level counter. Push, pop and flush come from the owner.
// Illegal push/pop and anything coinciding with flush are ignored here.
module uart_byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full      = (level == LW'(DEPTH));
   assign empty     = (level == '0);
   assign head_data = mem[rd_ptr];

   // Flush wins over both a same-cycle write and a same-cycle read.
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit-side buffer: queues producer words and launches them one at a time into the UART tx.
//
//   state        | meaning
//   ST_IDLE      | waiting for a queued word and an idle transmitter
//   ST_WAIT_ACK  | launch issued, waiting for uart_tx_busy to rise (bounded by ACK_TIMEOUT)
//   ST_WAIT_DONE | transmitter accepted the word, waiting for uart_tx_busy to fall
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int PAYLOAD_BITS = UART_PAYLOAD_BITS,
   parameter int DEPTH        = 16,
   parameter int ACK_TIMEOUT  = 15
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [PAYLOAD_BITS-1:0]  in_data,
   output logic                     in_ready,
   input  logic                     flush,
   input  logic                     uart_tx_busy,
   output logic                     uart_tx_en,
   output logic [PAYLOAD_BITS-1:0]  uart_tx_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     ack_err
);

   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   tx_fifo_state_t          state, state_nxt;
   logic [TW-1:0]           tmo_cnt, tmo_cnt_nxt;
   logic                    tx_en_nxt;
   logic [PAYLOAD_BITS-1:0] tx_data_nxt;
   logic                    ack_err_nxt;
   logic                    fifo_pop;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [PAYLOAD_BITS-1:0] head_data;

   assign in_ready = !fifo_full;

   uart_byte_fifo #(
      .WIDTH (PAYLOAD_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (in_valid && in_ready),
      .push_data (in_data),
      .pop       (fifo_pop),
      .flush     (flush),
      .head_data (head_data),
      .level     (level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         tmo_cnt      <= '0;
         uart_tx_en   <= 1'b0;
         uart_tx_data <= '0;
         ack_err      <= 1'b0;
      end else begin
         state        <= state_nxt;
         tmo_cnt      <= tmo_cnt_nxt;
         uart_tx_en   <= tx_en_nxt;
         uart_tx_data <= tx_data_nxt;
         ack_err      <= ack_err_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      tmo_cnt_nxt = tmo_cnt;
      tx_en_nxt   = 1'b0;
      tx_data_nxt = uart_tx_data;
      ack_err_nxt = ack_err;
      fifo_pop    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty && !uart_tx_busy) begin
               tx_en_nxt   = 1'b1;
               tx_data_nxt = head_data;
               fifo_pop    = 1'b1;
               tmo_cnt_nxt = '0;
               state_nxt   = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            if (uart_tx_busy) begin
               state_nxt = ST_WAIT_DONE;
            end else if (tmo_cnt == TW'(ACK_TIMEOUT - 1)) begin
               // Word already popped; it is dropped and the error is latched.
               ack_err_nxt = 1'b1;
               state_nxt   = ST_IDLE;
            end else begin
               tmo_cnt_nxt = tmo_cnt + TW'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (!uart_tx_busy) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple transmitter model driving uart_tx_busy.
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       flush;
   logic       uart_tx_busy;
   logic       uart_tx_en;
   logic [7:0] uart_tx_data;
   logic [4:0] level;
   logic       ack_err;

   int         n_checks = 0;
   int         n_fail = 0;
   int         model_en = 0;
   int         frame_len = 4;
   int         busy_cnt = 0;
   int         double_en = 0;
   logic       prev_en = 1'b0;
   logic [7:0] launches [$];

   uart_tx_fifo #(.PAYLOAD_BITS(8), .DEPTH(16), .ACK_TIMEOUT(15)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .flush        (flush),
      .uart_tx_busy (uart_tx_busy),
      .uart_tx_en   (uart_tx_en),
      .uart_tx_data (uart_tx_data),
      .level        (level),
      .ack_err      (ack_err)
   );

   always #5 clk = ~clk;

   // Launch monitor
   always @(posedge clk) begin
      #1;
      if (uart_tx_en === 1'b1) begin
         launches.push_back(uart_tx_data);
         if (prev_en === 1'b1) double_en++;
      end
      prev_en = uart_tx_en;
   end

   // Transmitter model: busy rises right after a launch and stays up frame_len cycles.
   always @(posedge clk) begin
      #1;
      if (model_en != 0) begin
         if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) uart_tx_busy = 1'b0;
         end else if (uart_tx_en === 1'b1) begin
            uart_tx_busy = 1'b1;
            busy_cnt = frame_len;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      model_en = 0;
      busy_cnt = 0;
      uart_tx_busy = 1'b0;
      in_valid = 1'b0;
      flush = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      launches.delete();
      double_en = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (uart_tx_en !== 1'b0) begin n_fail++; $display("FAIL reset_tx_en: got %0h expected 0", uart_tx_en); end
      n_checks++; if (uart_tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %0h expected 0", uart_tx_data); end
      n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0h expected 1", in_ready); end
      n_checks++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL reset_ack_err: got %0h expected 0", ack_err); end
   endtask

   task automatic test_single();
      do_reset();
      model_en = 1;
      frame_len = 4;
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 8'hA5;
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL single_level_after_write: got %0d expected 1", level); end
      n_checks++; if (uart_tx_en !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %0h expected 0", uart_tx_en); end
      @(negedge clk);
      n_checks++; if (uart_tx_en !== 1'b1) begin n_fail++; $display("FAIL single_launch_en: got %0h expected 1", uart_tx_en); end
      n_checks++; if (uart_tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_launch_data: got %0h expected a5", uart_tx_data); end
      n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL single_level_after_pop: got %0d expected 0", level); end
      @(negedge clk);
      n_checks++; if (uart_tx_en !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: got %0h expected 0", uart_tx_en); end
      repeat (12) @(negedge clk);
      n_checks++; if (launches.size() != 1) begin n_fail++; $display("FAIL single_launch_count: got %0d expected 1", launches.size()); end
      n_checks++; if (double_en != 0) begin n_fail++; $display("FAIL single_double_en: got %0d expected 0", double_en); end
   endtask

   task automatic test_burst();
      do_reset();
      uart_tx_busy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data = 8'(i);
      end
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL burst_full_ready: got %0h expected 0", in_ready); end
      n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL burst_full_level: got %0d expected 16", level); end
      in_data = 8'hEE;
      repeat (2) @(negedge clk);
      n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL burst_17th_rejected: got %0d expected 16", level); end
      in_valid = 1'b0;
      uart_tx_busy = 1'b0;
      frame_len = 4;
      model_en = 1;
      for (int k = 0; k < 20 && uart_tx_en !== 1'b1; k++) @(negedge clk);
      n_checks++; if (uart_tx_en !== 1'b1) begin n_fail++; $display("FAIL burst_first_launch: got %0h expected 1", uart_tx_en); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL burst_ready_after_pop: got %0h expected 1", in_ready); end
      n_checks++; if (level !== 5'd15) begin n_fail++; $display("FAIL burst_level_after_pop: got %0d expected 15", level); end
      for (int k = 0; k < 2000 && launches.size() < 16; k++) @(negedge clk);
      repeat (10) @(negedge clk);
      n_checks++; if (launches.size() != 16) begin n_fail++; $display("FAIL burst_launch_count: got %0d expected 16", launches.size()); end
      for (int i = 0; i < 16 && i < launches.size(); i++) begin
         n_checks++; if (launches[i] !== 8'(i)) begin n_fail++; $display("FAIL burst_order[%0d]: got %0h expected %0h", i, launches[i], i); end
      end
      n_checks++; if (double_en != 0) begin n_fail++; $display("FAIL burst_double_en: got %0d expected 0", double_en); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      uart_tx_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data = 8'h40 + 8'(i);
      end
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++; if (level !== 5'd5) begin n_fail++; $display("FAIL simul_prefill_level: got %0d expected 5", level); end
      // Each iteration: launch+write on one edge, busy ack, busy release.
      for (int i = 0; i < 40; i++) begin
         uart_tx_busy = 1'b0;
         in_valid = 1'b1;
         in_data = 8'h45 + 8'(i);
         @(negedge clk);
         in_valid = 1'b0;
         n_checks++; if (level !== 5'd5) begin n_fail++; $display("FAIL simul_level[%0d]: got %0d expected 5", i, level); end
         n_checks++; if (uart_tx_en !== 1'b1) begin n_fail++; $display("FAIL simul_en[%0d]: got %0h expected 1", i, uart_tx_en); end
         n_checks++; if (uart_tx_data !== 8'h40 + 8'(i)) begin n_fail++; $display("FAIL simul_data[%0d]: got %0h expected %0h", i, uart_tx_data, 8'h40 + 8'(i)); end
         uart_tx_busy = 1'b1;
         @(negedge clk);
         uart_tx_busy = 1'b0;
         @(negedge clk);
      end
      uart_tx_busy = 1'b1;
      @(negedge clk);
      n_checks++; if (double_en != 0) begin n_fail++; $display("FAIL simul_double_en: got %0d expected 0", double_en); end
   endtask

   task automatic test_flush();
      do_reset();
      uart_tx_busy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data = 8'h80 + 8'(i);
      end
      @(negedge clk);
      in_valid = 1'b0;
      uart_tx_busy = 1'b0;
      frame_len = 8;
      model_en = 1;
      for (int k = 0; k < 20 && uart_tx_en !== 1'b1; k++) @(negedge clk);
      n_checks++; if (uart_tx_en !== 1'b1) begin n_fail++; $display("FAIL flush_launch_seen: got %0h expected 1", uart_tx_en); end
      n_checks++; if (level !== 5'd7) begin n_fail++; $display("FAIL flush_level_before: got %0d expected 7", level); end
      flush = 1'b1;
      in_valid = 1'b1;
      in_data = 8'h99;
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL flush_level_after: got %0d expected 0", level); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_after: got %0h expected 1", in_ready); end
      repeat (20) @(negedge clk);
      n_checks++; if (launches.size() != 1) begin n_fail++; $display("FAIL flush_launch_count: got %0d expected 1", launches.size()); end
      if (launches.size() > 0) begin
         n_checks++; if (launches[0] !== 8'h80) begin n_fail++; $display("FAIL flush_inflight_word: got %0h expected 80", launches[0]); end
      end
      in_valid = 1'b1;
      in_data = 8'h3C;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (uart_tx_en !== 1'b1) begin n_fail++; $display("FAIL flush_next_launch_en: got %0h expected 1", uart_tx_en); end
      n_checks++; if (uart_tx_data !== 8'h3C) begin n_fail++; $display("FAIL flush_next_launch_data: got %0h expected 3c", uart_tx_data); end
      repeat (15) @(negedge clk);
   endtask

   task automatic test_timeout();
      do_reset();
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 8'hC1;
      @(negedge clk);
      in_data = 8'hC2;
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++; if (uart_tx_en !== 1'b1) begin n_fail++; $display("FAIL timeout_launch_en: got %0h expected 1", uart_tx_en); end
      n_checks++; if (uart_tx_data !== 8'hC1) begin n_fail++; $display("FAIL timeout_launch_data: got %0h expected c1", uart_tx_data); end
      n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL timeout_level_simul: got %0d expected 1", level); end
      repeat (14) @(negedge clk);
      n_checks++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL timeout_not_early: got %0h expected 0", ack_err); end
      n_checks++; if (uart_tx_en !== 1'b0) begin n_fail++; $display("FAIL timeout_no_relaunch: got %0h expected 0", uart_tx_en); end
      @(negedge clk);
      n_checks++; if (ack_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_set: got %0h expected 1", ack_err); end
      n_checks++; if (uart_tx_en !== 1'b0) begin n_fail++; $display("FAIL timeout_en_low_at_err: got %0h expected 0", uart_tx_en); end
      @(negedge clk);
      n_checks++; if (uart_tx_en !== 1'b1) begin n_fail++; $display("FAIL timeout_next_launch_en: got %0h expected 1", uart_tx_en); end
      n_checks++; if (uart_tx_data !== 8'hC2) begin n_fail++; $display("FAIL timeout_next_launch_data: got %0h expected c2", uart_tx_data); end
      n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL timeout_level_end: got %0d expected 0", level); end
   endtask

   task automatic test_reset_mid();
      repeat (20) @(negedge clk);
      n_checks++; if (ack_err !== 1'b1) begin n_fail++; $display("FAIL midreset_err_sticky: got %0h expected 1", ack_err); end
      uart_tx_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data = 8'hD0 + 8'(i);
      end
      @(negedge clk);
      in_valid = 1'b0;
      launches.delete();
      uart_tx_busy = 1'b0;
      frame_len = 30;
      model_en = 1;
      for (int k = 0; k < 20 && uart_tx_en !== 1'b1; k++) @(negedge clk);
      n_checks++; if (uart_tx_data !== 8'hD0) begin n_fail++; $display("FAIL midreset_launch_data: got %0h expected d0", uart_tx_data); end
      repeat (3) @(negedge clk);
      n_checks++; if (level !== 5'd3) begin n_fail++; $display("FAIL midreset_level_before: got %0d expected 3", level); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL midreset_level: got %0d expected 0", level); end
      n_checks++; if (uart_tx_en !== 1'b0) begin n_fail++; $display("FAIL midreset_tx_en: got %0h expected 0", uart_tx_en); end
      n_checks++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL midreset_ack_err: got %0h expected 0", ack_err); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %0h expected 1", in_ready); end
      repeat (5) @(negedge clk);
      n_checks++; if (launches.size() != 1) begin n_fail++; $display("FAIL midreset_no_relaunch: got %0d expected 1", launches.size()); end
      model_en = 0;
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;
      flush = 1'b0;
      uart_tx_busy = 1'b0;
      test_reset();
      test_single();
      test_burst();
      test_simultaneous();
      test_flush();
      test_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
